// File: rtl/note_pkg.sv
// note_pkg: note codes, scheduler states and clock constant shared by the note scheduler
package note_pkg;
  localparam logic [2:0] NOTE_A    = 3'd0;
  localparam logic [2:0] NOTE_B    = 3'd1;
  localparam logic [2:0] NOTE_C    = 3'd2;
  localparam logic [2:0] NOTE_D    = 3'd3;
  localparam logic [2:0] NOTE_E    = 3'd4;
  localparam logic [2:0] NOTE_F    = 3'd5;
  localparam logic [2:0] NOTE_G    = 3'd6;
  localparam logic [2:0] NOTE_REST = 3'd7;
  localparam int CLK_HZ = 50_000_000;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
endpackage

// File: rtl/duration_timer.sv
// duration_timer: loadable down-counter that holds at zero; zero flags expiry
// ports: load/load_value reload the count, en decrements, zero = count is 0
module duration_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] count_d, count_q;
  always_comb begin
    count_d = load ? load_value : (en && count_q != '0) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign zero = count_q == '0;
endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: arbitrates live strums and song notes onto one tone generator with note/gap timing
// ports: live_valid/live_note strum pulse, song_valid/song_note/song_ready song handshake,
//        note_out registered note code (7 = silence), playing, source (0 live, 1 song), note_done pulse
module note_scheduler
  import note_pkg::*;
#(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       live_valid,
  input  logic [2:0] live_note,
  input  logic       song_valid,
  input  logic [2:0] song_note,
  output logic       song_ready,
  output logic [2:0] note_out,
  output logic       playing,
  output logic       source,
  output logic       note_done
);
  state_e state_d, state_q;
  logic [2:0] note_d, note_q;
  logic playing_d, playing_q, source_d, source_q, done_d, done_q;
  logic live_acc, song_acc, load, en, zero;
  logic [CNT_W-1:0] load_value;
  duration_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .en(en), .zero(zero)
  );
  assign live_acc   = live_valid && live_note != NOTE_REST;
  assign song_ready = state_q == IDLE && !live_acc;
  assign song_acc   = song_valid && song_ready;
  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    source_d   = source_q;
    done_d     = 1'b0;
    load       = 1'b0;
    en         = 1'b0;
    load_value = CNT_W'(NOTE_CYCLES - 1);
    if (live_acc || song_acc) begin
      state_d  = PLAY;
      note_d   = live_acc ? live_note : song_note;
      source_d = !live_acc;
      load     = 1'b1;
    end else if (state_q == PLAY) begin
      if (zero) begin
        done_d     = 1'b1;
        note_d     = NOTE_REST;
        state_d    = GAP_CYCLES > 0 ? GAP : IDLE;
        load       = GAP_CYCLES > 0;
        load_value = CNT_W'(GAP_CYCLES - 1);
      end else en = 1'b1;
    end else if (state_q == GAP) begin
      state_d = zero ? IDLE : GAP;
      en      = !zero;
    end
    playing_d = state_d == PLAY && note_d != NOTE_REST;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      note_q    <= NOTE_REST;
      playing_q <= 1'b0;
      source_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      playing_q <= playing_d;
      source_q  <= source_d;
      done_q    <= done_d;
    end
  end
  assign note_out  = note_q;
  assign playing   = playing_q;
  assign source    = source_q;
  assign note_done = done_q;
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed plan plus random stimulus against an age-based note model
module tb_note_scheduler;
  localparam int N = 4;
  localparam int G = 2;
  logic clk = 1'b0, reset = 1'b1, live_valid = 1'b0, song_valid = 1'b0;
  logic [2:0] live_note = 3'd7, song_note = 3'd7;
  logic song_ready, playing, source, note_done;
  logic [2:0] note_out;
  int n_checks = 0, n_fail = 0;
  bit m_active = 0, m_src = 0, pend = 0;
  int m_note = 7, m_age = 0;
  logic [2:0] pend_note = 3'd0;

  note_scheduler #(.NOTE_CYCLES(N), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .live_valid(live_valid), .live_note(live_note),
    .song_valid(song_valid), .song_note(song_note), .song_ready(song_ready),
    .note_out(note_out), .playing(playing), .source(source), .note_done(note_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // The model tracks how many cycles ago the current note became visible;
  // every output is a plain function of that age and the stored note.
  task automatic step(input bit rs, input bit lv, input logic [2:0] ln, input bit sv, input logic [2:0] sn);
    bit live_acc, idle, rdy;
    reset = rs; live_valid = lv; live_note = ln; song_valid = sv; song_note = sn;
    #1;
    live_acc = lv && ln != 3'd7;
    idle = !m_active || m_age > N + G;
    rdy = idle && !live_acc;
    if (!rs) check("song_ready", int'(song_ready), int'(rdy));
    @(posedge clk);
    #1;
    if (rs) begin
      m_active = 0; m_src = 0; m_age = 0;
    end else if (live_acc || (sv && rdy)) begin
      m_active = 1; m_age = 1;
      m_note = live_acc ? int'(ln) : int'(sn);
      m_src = !live_acc;
    end else if (m_active && m_age < 1000) m_age++;
    check("note_out", int'(note_out), (m_active && m_age <= N) ? m_note : 7);
    check("playing", int'(playing), int'(m_active && m_age <= N && m_note != 7));
    check("source", int'(source), int'(m_src));
    check("note_done", int'(note_done), int'(m_active && m_age == N + 1));
    if (!rs && sv && rdy && !live_acc) pend = 0;
  endtask

  initial begin
    step(1, 0, 7, 0, 7);
    step(1, 0, 7, 0, 7);
    repeat (3) step(0, 0, 7, 0, 7);
    step(0, 0, 7, 1, 3'd2);
    repeat (8) step(0, 0, 7, 0, 7);
    step(0, 0, 7, 1, 3'd4);
    step(0, 0, 7, 0, 7);
    step(0, 1, 3'd0, 0, 7);
    repeat (8) step(0, 0, 7, 0, 7);
    step(0, 1, 3'd6, 1, 3'd3);
    repeat (12) step(0, 0, 7, !m_active || m_age <= N + G || m_note != 3, 3'd3);
    step(0, 0, 7, 1, 3'd7);
    repeat (8) step(0, 0, 7, 0, 7);
    step(0, 1, 3'd7, 0, 7);
    step(0, 0, 7, 0, 7);
    step(0, 0, 7, 1, 3'd5);
    step(0, 0, 7, 0, 7);
    step(1, 0, 7, 0, 7);
    repeat (3) step(0, 0, 7, 0, 7);
    for (int i = 0; i < 3000; i++) begin
      bit rs, lv;
      logic [2:0] ln;
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1;
        pend_note = 3'($urandom_range(0, 7));
      end
      rs = $urandom_range(0, 299) == 0;
      lv = $urandom_range(0, 11) == 0;
      ln = 3'($urandom_range(0, 7));
      step(rs, lv, ln, pend, pend_note);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
